// File: rtl/automat_pkg.sv
// automat_pkg: shared definitions for the serial-automaton sequencer.
// State encoding (2-bit) and a clog2 helper used to size the bit counter.
// Optional build macro SEQ_CTRL_FIXED_PRIO_EN is consumed by automat_rr_arb and automat_seq_ctrl.
package automat_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLR   = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Smallest r with 2**r >= v.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/automat_rr_arb.sv
// automat_rr_arb: NREQ-wide requester arbiter producing a one-hot grant and the winner id.
// Purely combinational; the caller decides when to act on the result.
// Macro SEQ_CTRL_FIXED_PRIO_EN: lowest index wins and ptr is ignored; default is round-robin after ptr.
module automat_rr_arb
   import automat_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic            any,
   output logic [NREQ-1:0] gnt_oh,
   output logic [IDW-1:0]  gnt_id
);

`ifdef SEQ_CTRL_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   // Fixed priority: first set request from index 0 upward.
   always_comb begin
      any    = 1'b0;
      gnt_oh = '0;
      gnt_id = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (!any && req[j]) begin
            any       = 1'b1;
            gnt_oh[j] = 1'b1;
            gnt_id    = IDW'(j);
         end
      end
   end
`else
   // Round-robin: scan indices above ptr first, then wrap to 0..ptr, so the last winner goes last.
   always_comb begin
      any    = 1'b0;
      gnt_oh = '0;
      gnt_id = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (!any && req[j] && (j > int'(ptr))) begin
            any       = 1'b1;
            gnt_oh[j] = 1'b1;
            gnt_id    = IDW'(j);
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!any && req[j] && (j <= int'(ptr))) begin
            any       = 1'b1;
            gnt_oh[j] = 1'b1;
            gnt_id    = IDW'(j);
         end
      end
   end
`endif

endmodule

// File: rtl/automat_seq_ctrl.sv
// automat_seq_ctrl: picks a requester, resets the automaton, shifts the word MSB-first onto fsm_x
// and counts fsm_t pulses per output (saturating). Accept-to-done W+2 cycles, W+3 cycles per job.
// Requesters hold req until gnt; req is ignored outside IDLE. Macro SEQ_CTRL_FIXED_PRIO_EN freezes the pointer.
module automat_seq_ctrl
   import automat_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int W    = 8,
   parameter int NOUT = 5,
   parameter int CW   = 4
) (
   input  logic                 clk,
   input  logic                 res,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*W-1:0]    word,
   output logic [NREQ-1:0]      gnt,
   output logic                 busy,
   output logic                 fsm_res,
   output logic                 fsm_x,
   input  logic [NOUT-1:0]      fsm_t,
   output logic                 done,
   output logic [IDW-1:0]       done_id,
   output logic [NOUT*CW-1:0]   hits
);

   localparam int             BCW      = clog2(W + 1);
   localparam logic [IDW-1:0] PTR_RST  = IDW'(NREQ - 1);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(W - 1);
   localparam logic [CW-1:0]  HIT_MAX  = {CW{1'b1}};

   state_t          state_q, state_d;
   logic [W-1:0]    sreg_q, sreg_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [IDW-1:0]  done_id_q, done_id_d;
   logic [BCW-1:0]  bcnt_q, bcnt_d;
   logic [CW-1:0]   hits_q [NOUT];
   logic [CW-1:0]   hits_d [NOUT];
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            busy_q, busy_d;
   logic            fsm_res_q, fsm_res_d;
   logic            fsm_x_q, fsm_x_d;
   logic            done_q, done_d;

   logic            arb_any;
   logic [NREQ-1:0] arb_oh;
   logic [IDW-1:0]  arb_id;

   automat_rr_arb #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req    (req),
      .ptr    (ptr_q),
      .any    (arb_any),
      .gnt_oh (arb_oh),
      .gnt_id (arb_id)
   );

   // Next-state and next-output logic; outputs are derived from the next state so they come straight off flops.
   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      id_d      = id_q;
      ptr_d     = ptr_q;
      done_id_d = done_id_q;
      bcnt_d    = bcnt_q;
      hits_d    = hits_q;
      gnt_d     = '0;

      case (state_q)
         S_IDLE: begin
            if (arb_any) begin
               state_d = S_CLR;
               id_d    = arb_id;
               gnt_d   = arb_oh;
               bcnt_d  = '0;
               for (int k = 0; k < NOUT; k++) hits_d[k] = '0;
               for (int j = 0; j < NREQ; j++) begin
                  if (arb_oh[j]) sreg_d = word[j*W +: W];
               end
            end
         end
         S_CLR: begin
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            for (int k = 0; k < NOUT; k++) begin
               if (fsm_t[k] && (hits_q[k] != HIT_MAX)) hits_d[k] = hits_q[k] + 1'b1;
            end
            sreg_d = sreg_q << 1;
            bcnt_d = bcnt_q + 1'b1;
            if (bcnt_q == LAST_BIT) begin
               state_d   = S_DONE;
               done_id_d = id_q;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
`ifndef SEQ_CTRL_FIXED_PRIO_EN
            ptr_d   = id_q;
`endif
         end
         default: state_d = S_IDLE;
      endcase

      busy_d    = (state_d != S_IDLE);
      fsm_res_d = (state_d != S_SHIFT);
      fsm_x_d   = (state_d == S_SHIFT) && sreg_d[W-1];
      done_d    = (state_d == S_DONE);
   end

   // Single state register for the FSM, its datapath and its registered outputs.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q   <= S_IDLE;
         sreg_q    <= '0;
         id_q      <= '0;
         ptr_q     <= PTR_RST;
         done_id_q <= '0;
         bcnt_q    <= '0;
         for (int k = 0; k < NOUT; k++) hits_q[k] <= '0;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         fsm_res_q <= 1'b1;
         fsm_x_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sreg_q    <= sreg_d;
         id_q      <= id_d;
         ptr_q     <= ptr_d;
         done_id_q <= done_id_d;
         bcnt_q    <= bcnt_d;
         hits_q    <= hits_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         fsm_res_q <= fsm_res_d;
         fsm_x_q   <= fsm_x_d;
         done_q    <= done_d;
      end
   end

   assign gnt     = gnt_q;
   assign busy    = busy_q;
   assign fsm_res = fsm_res_q;
   assign fsm_x   = fsm_x_q;
   assign done    = done_q;
   assign done_id = done_id_q;

   for (genvar k = 0; k < NOUT; k++) begin : g_hits
      assign hits[k*CW +: CW] = hits_q[k];
   end

endmodule
